// File: rtl/dmemory_sized_if.sv
// Bus bundle for dmemory_sized: registered load/store port A, combinational word-read port B.
// master = requester (MEM stage / bench), slave = the memory.
interface dmemory_sized_if #(
    parameter int B     = 8,
    parameter int N     = 8,
    parameter int LANES = 4
);
    // a_req is a single-cycle command: a request present at a posedge while the memory is not
    // busy is always taken, and answered by exactly one a_ack pulse in the following cycle.
    logic                 busy;
    logic                 a_req;
    logic                 a_we;
    logic [1:0]           a_size;
    logic                 a_signed;
    logic [N-1:0]         a_addr;
    logic [LANES*B-1:0]   a_wdata;
    logic [LANES*B-1:0]   a_rdata;
    logic                 a_ack;
    logic                 a_err;
    logic [N-1:0]         b_addr;
    logic [LANES*B-1:0]   b_rdata;

    modport master (
        input  busy, a_rdata, a_ack, a_err, b_rdata,
        output a_req, a_we, a_size, a_signed, a_addr, a_wdata, b_addr
    );

    modport slave (
        output busy, a_rdata, a_ack, a_err, b_rdata,
        input  a_req, a_we, a_size, a_signed, a_addr, a_wdata, b_addr
    );
endinterface

// File: rtl/dmemory_sized.sv
// Byte-addressable big-endian data memory with byte/half/word load-store port and a word read port.
// Optional macro DMEM_MISALIGN_TRAP_EN: reject misaligned half/word accesses with a_err.
module dmemory_sized #(
    parameter int B     = 8,
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmemory_sized_if.slave         bus,
    output logic [1:0]             o_dbg_state
);
    localparam int W     = LANES * B;
    localparam int DEPTH = 2 ** N;
    localparam int WORDS = DEPTH / LANES;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_clr_cnt;
    logic           r_busy;
    logic           r_ack;
    logic           r_err;
    logic [W-1:0]   r_rdata;
    logic [B-1:0]   r_mem [DEPTH];

    logic           w_take;
    logic           w_bad;
    int             w_k;
    logic [W-1:0]   w_ld;
    logic [W-1:0]   w_mask;
    logic [N-1:0]   w_aaddr [LANES];
    logic [N-1:0]   w_waddr [LANES];
    logic [B-1:0]   w_wbyte [LANES];
    logic           w_wen   [LANES];
    logic [N-1:0]   w_baddr [LANES];
    logic [W-1:0]   w_b;

    always_comb begin
        w_take = rst_n && (r_state == ST_IDLE) && bus.a_req;
        case (bus.a_size)
            2'b00:   w_k = 1;
            2'b01:   w_k = 2;
            2'b10:   w_k = LANES;
            default: w_k = 0;
        endcase
        w_bad = (bus.a_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (bus.a_size == 2'b01 && bus.a_addr[0]) begin
            w_bad = 1'b1;
        end
        if (bus.a_size == 2'b10 && (int'(bus.a_addr) % LANES) != 0) begin
            w_bad = 1'b1;
        end
`endif
        // Gather k locations big-endian; w_mask marks the bits actually loaded.
        w_ld   = '0;
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_aaddr[i] = bus.a_addr + N'(i);
            if (i < w_k) begin
                w_ld   = (w_ld << B) | W'(r_mem[w_aaddr[i]]);
                w_mask = (w_mask << B) | W'({B{1'b1}});
            end
        end
        if (bus.a_signed && (|(w_ld & w_mask & ~(w_mask >> 1)))) begin
            w_ld = w_ld | ~w_mask;
        end

        // Write lanes serve both the init clear and port-A stores.
        for (int i = 0; i < LANES; i++) begin
            w_wen[i]   = 1'b0;
            w_waddr[i] = w_aaddr[i];
            w_wbyte[i] = '0;
            if (r_state == ST_INIT) begin
                w_wen[i]   = 1'b1;
                w_waddr[i] = N'(int'(r_clr_cnt) * LANES + i);
            end else if (w_take && bus.a_we && !w_bad && (i < w_k)) begin
                w_wen[i]   = 1'b1;
                w_wbyte[i] = B'(bus.a_wdata >> ((w_k - 1 - i) * B));
            end
        end
    end

    always_comb begin
        w_b = '0;
        for (int i = 0; i < LANES; i++) begin
            w_baddr[i] = bus.b_addr + N'(i);
            w_b        = (w_b << B) | W'(r_mem[w_baddr[i]]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_wen[i]) begin
                r_mem[w_waddr[i]] <= w_wbyte[i];
            end
        end
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack <= w_take;
            r_err <= w_take && w_bad;
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + N'(1);
                    if (r_clr_cnt == N'(WORDS - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (w_take && !bus.a_we && !w_bad) begin
                        r_rdata <= w_ld;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.a_ack   = r_ack;
    assign bus.a_err   = r_err;
    assign bus.a_rdata = r_rdata;
    assign bus.b_rdata = w_b;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dmemory_sized.sv
// Self-checking bench for dmemory_sized: byte-array reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmemory_sized;
    localparam int B = 8, N = 8, LANES = 4, W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    dmemory_sized_if #(.B(B), .N(N), .LANES(LANES)) bus ();
    dmemory_sized #(.B(B), .N(N), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the array as plain bytes, updated by the rules at each rising edge.
    logic [7:0]  m [256];
    bit          in_init   = 1'b1;
    bit          mem_known = 1'b0;
    int          clr       = 0;
    logic        exp_busy, exp_ack, exp_err;
    logic [31:0] exp_rdata;
    int          mk;
    bit          mbad;
    longint      mv;

    function automatic logic [31:0] model_word(input logic [7:0] a);
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v = (v << 8) | 32'(m[(int'(a) + i) % 256]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            in_init = 1; clr = 0; exp_busy = 1; exp_ack = 0; exp_err = 0; exp_rdata = 0;
        end else if (in_init) begin
            for (int j = 0; j < 4; j++) m[clr * 4 + j] = 8'h00;
            clr++;
            exp_ack = 0; exp_err = 0;
            if (clr == 64) begin
                in_init = 0; exp_busy = 0; mem_known = 1;
            end
        end else begin
            exp_ack = bus.a_req;
            exp_err = 0;
            if (bus.a_req) begin
                mk = (bus.a_size == 2'd0) ? 1 : (bus.a_size == 2'd1) ? 2 : (bus.a_size == 2'd2) ? 4 : 0;
                mbad = (bus.a_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
                if ((mk == 2 && int'(bus.a_addr) % 2 != 0) || (mk == 4 && int'(bus.a_addr) % 4 != 0)) mbad = 1;
`endif
                exp_err = mbad;
                if (!mbad) begin
                    if (bus.a_we) begin
                        for (int i = 0; i < mk; i++)
                            m[(int'(bus.a_addr) + i) % 256] = 8'(bus.a_wdata >> (8 * (mk - 1 - i)));
                    end else begin
                        mv = 0;
                        for (int i = 0; i < mk; i++) mv = mv * 256 + longint'(m[(int'(bus.a_addr) + i) % 256]);
                        if (bus.a_signed && mk < 4 && mv >= (longint'(1) << (8 * mk - 1)))
                            mv = mv - (longint'(1) << (8 * mk));
                        exp_rdata = 32'(mv);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("a_ack", 32'(bus.a_ack), 32'(exp_ack));
            check("a_err", 32'(bus.a_err), 32'(exp_err));
            check("a_rdata", bus.a_rdata, exp_rdata);
            if (mem_known) check("b_rdata", bus.b_rdata, model_word(bus.b_addr));
        end
    end

    // Called at posedge+2; the request is sampled at the next edge, then dropped.
    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [7:0] addr, input logic [31:0] wdata);
        bus.a_req = 1; bus.a_we = we; bus.a_size = size; bus.a_signed = sgn;
        bus.a_addr = addr; bus.a_wdata = wdata;
        @(posedge clk); #2;
        bus.a_req = 0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, 32'(n), 32'd64);
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_size = 0; bus.a_signed = 0;
        bus.a_addr = 0; bus.a_wdata = 0; bus.b_addr = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1;
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_ack", 32'(bus.a_ack), 32'd0);
        check("rst_rdata", bus.a_rdata, 32'd0);
        rst_n = 1;
        wait_init("init_cycles");

        bus.b_addr = 8'h00; #1; check("clr_b00", bus.b_rdata, 32'h0);
        bus.b_addr = 8'h40; #1; check("clr_b40", bus.b_rdata, 32'h0);
        bus.b_addr = 8'hFC; #1; check("clr_bFC", bus.b_rdata, 32'h0);
        @(posedge clk); #2;

        issue(1, 2'd2, 0, 8'h10, 32'hDEADBEEF);
        check("st_word_ack", 32'(bus.a_ack), 32'd1);
        issue(0, 2'd0, 1, 8'h11, 32'h0);
        check("ld_byte_s", bus.a_rdata, 32'hFFFFFFAD);
        issue(0, 2'd1, 0, 8'h12, 32'h0);
        check("ld_half_u", bus.a_rdata, 32'h0000BEEF);
        bus.b_addr = 8'h10; #1;
        check("b_word", bus.b_rdata, 32'hDEADBEEF);

        issue(1, 2'd0, 0, 8'h13, 32'h0000007F);
        check("st_byte_ack", 32'(bus.a_ack), 32'd1);
        issue(0, 2'd2, 0, 8'h10, 32'h0);
        check("raw_ack", 32'(bus.a_ack), 32'd1);
        check("raw_data", bus.a_rdata, 32'hDEADBE7F);

        issue(0, 2'd3, 0, 8'h10, 32'h0);
        check("rsv_ack", 32'(bus.a_ack), 32'd1);
        check("rsv_err", 32'(bus.a_err), 32'd1);
        check("rsv_keep", bus.a_rdata, 32'hDEADBE7F);

        issue(1, 2'd2, 0, 8'hFE, 32'h11223344);
        bus.b_addr = 8'hFE; #1;
`ifdef DMEM_MISALIGN_TRAP_EN
        check("wrap_err", 32'(bus.a_err), 32'd1);
        check("wrap_b", bus.b_rdata, 32'h00000000);
`else
        check("wrap_err", 32'(bus.a_err), 32'd0);
        check("wrap_b", bus.b_rdata, 32'h11223344);
        bus.b_addr = 8'hFC; #1;
        check("wrap_bFC", bus.b_rdata, 32'h00001122);
`endif

        // Reset lands on the edge after a store: the pending ack is dropped and the clear restarts.
        issue(1, 2'd2, 0, 8'h20, 32'hCAFEF00D);
        check("pre_rst_ack", 32'(bus.a_ack), 32'd1);
        rst_n = 0;
        @(posedge clk); #2;
        check("mid_rst_ack", 32'(bus.a_ack), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1;
        wait_init("reinit_cycles");
        bus.b_addr = 8'h20; #1;
        check("reinit_b20", bus.b_rdata, 32'h0);
        bus.b_addr = 8'h10; #1;
        check("reinit_b10", bus.b_rdata, 32'h0);

        for (int it = 0; it < 1500; it++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
            bus.b_addr = 8'($urandom_range(0, 31) + ($urandom_range(0, 1) ? 32'hE8 : 32'h0));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 31) + ($urandom_range(0, 1) ? 32'hE8 : 32'h0)), $urandom);
        end
        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
